traffic_light_monitor: RTL
==========================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the phase-duration counter and the phase_len output.
REQ-002 Parameter CYC_W, default 8: width of the completed-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 R  input  1  red lamp, driven by the traffic light controller; asynchronous to nothing, same clk domain.
REQ-006 G  input  1  green lamp.
REQ-007 Y  input  1  yellow lamp.
REQ-008 clr  input  1  synchronous clear of sticky errors and cycle_cnt.
REQ-009 phase  output  3  current decoded phase: 0=OFF, 1=RED, 2=GREEN, 3=YELLOW, 4=ILLEGAL.
REQ-010 phase_len  output  CNT_W  duration in clk cycles of the most recently completed phase.
REQ-011 len_valid  output  1  one-cycle pulse when phase_len updates.
REQ-012 err_onehot  output  1  sticky; set when two or more lamps are on together.
REQ-013 err_seq  output  1  sticky; set on an illegal phase transition.
REQ-014 cycle_cnt  output  CYC_W  count of completed RED->GREEN transitions.

Function
REQ-015 The block shall register {R,G,Y} into a sample register every cycle (stage 1).
REQ-016 The block shall decode the sample register combinationally as follows: none on = OFF; exactly R = RED; exactly G = GREEN; exactly Y = YELLOW; more than one on = ILLEGAL.
REQ-017 Stage 2: when the decoded sample differs from phase, the block shall, on the same edge, load phase with the decoded value, load phase_len with run_cnt, pulse len_valid, and set run_cnt to 1.
REQ-018 When the decoded sample equals phase, run_cnt shall increment by 1 and saturate at 2^CNT_W-1; no wrap.
REQ-019 Latency: a lamp change present before edge N shall appear on phase after edge N+1 (2 cycles).
REQ-020 Legal transitions: OFF->GREEN, GREEN->OFF, GREEN->YELLOW, YELLOW->RED, RED->GREEN.
REQ-021 Any other transition between non-ILLEGAL phases shall set err_seq.
REQ-022 A transition into ILLEGAL shall set err_onehot only.
REQ-023 A transition out of ILLEGAL shall set neither flag.
REQ-024 A RED->GREEN transition shall increment cycle_cnt, which wraps modulo 2^CYC_W.
REQ-025 clr=1 shall clear err_onehot, err_seq and cycle_cnt on the next edge.
REQ-026 When clr=1 and an error or cycle event occur on the same edge, the event shall win: the flag is set, or cycle_cnt becomes 1.
REQ-027 clr shall not affect phase, phase_len, run_cnt, or len_valid.
REQ-028 len_valid shall be high for exactly one cycle per phase change; back-to-back changes shall produce consecutive pulses.

Reset
REQ-029 rst=0 shall immediately force the following: sample register=0, phase=OFF, run_cnt=0, phase_len=0, len_valid=0, err_onehot=0, err_seq=0, cycle_cnt=0.
REQ-030 Reset asserted mid-phase shall discard the partial duration; no len_valid is produced for it.
REQ-031 After release, the first change from OFF shall report phase_len equal to the cycles elapsed since release, counted per REQ-018.

Verification
REQ-032 Bench shall cover: reset release with G=1 held -> phase=GREEN 2 cycles later, len_valid pulse with phase_len=0 or 1 per run_cnt, no errors.
REQ-033 Bench shall cover: G held 10 cycles, then Y 5, then R 8, then G -> phase_len reports 10, 5, 8 on successive len_valid pulses; cycle_cnt=1; err_seq=0.
REQ-034 Bench shall cover: GREEN->RED directly -> err_seq=1 and stays 1 through later legal traffic until clr.
REQ-035 Bench shall cover: R=G=1 for 1 cycle -> phase=ILLEGAL, err_onehot=1, err_seq=0; return to RED sets no new flag.
REQ-036 Bench shall cover: CNT_W=4 with GREEN held 40 cycles -> phase_len=15 (saturated); CYC_W=2 with 5 full cycles -> cycle_cnt=1 (wrapped).
REQ-037 Bench shall cover: clr pulsed on the same edge as a RED->GREEN transition -> cycle_cnt=1; rst=0 asserted mid-YELLOW -> all outputs 0 immediately, with no len_valid on release.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic light lamp monitor: samples the three lamp inputs, tracks the decoded
// phase and its duration, and flags illegal lamp combinations and sequences.
module traffic_light_monitor #(
  parameter int CNT_W = 16,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             R,
  input  logic             G,
  input  logic             Y,
  input  logic             clr,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] phase_len,
  output logic             len_valid,
  output logic             err_onehot,
  output logic             err_seq,
  output logic [CYC_W-1:0] cycle_cnt
);

  // state       | meaning
  // PH_OFF      | no lamp lit
  // PH_RED      | only red lit
  // PH_GREEN    | only green lit
  // PH_YELLOW   | only yellow lit
  // PH_ILLEGAL  | two or more lamps lit together
  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_RED     = 3'd1,
    PH_GREEN   = 3'd2,
    PH_YELLOW  = 3'd3,
    PH_ILLEGAL = 3'd4
  } phase_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [2:0]       sample_q;
  phase_e           dec_phase;
  phase_e           phase_q;
  phase_e           phase_nxt;
  logic             phase_change;
  logic [CNT_W-1:0] run_cnt;
  logic             ev_onehot;
  logic             ev_seq;
  logic             ev_cycle;

  function automatic logic legal_step(input phase_e cur, input phase_e nxt);
    logic ok;
    ok = 1'b0;
    unique case (cur)
      PH_OFF:    ok = (nxt == PH_GREEN);
      PH_GREEN:  ok = (nxt == PH_OFF) || (nxt == PH_YELLOW);
      PH_YELLOW: ok = (nxt == PH_RED);
      PH_RED:    ok = (nxt == PH_GREEN);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= 3'b000;
    end else begin
      sample_q <= {R, G, Y};
    end
  end

  always_comb begin
    dec_phase = PH_ILLEGAL;
    case (sample_q)
      3'b000:  dec_phase = PH_OFF;
      3'b100:  dec_phase = PH_RED;
      3'b010:  dec_phase = PH_GREEN;
      3'b001:  dec_phase = PH_YELLOW;
      default: dec_phase = PH_ILLEGAL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_OFF;
    end else begin
      phase_q <= phase_nxt;
    end
  end

  // Next state: the phase simply follows the decoded sample
  always_comb begin
    phase_nxt    = dec_phase;
    phase_change = (dec_phase != phase_q);
  end

  // Output events; leaving ILLEGAL is never blamed on the sequence checker
  always_comb begin
    ev_onehot = 1'b0;
    ev_seq    = 1'b0;
    ev_cycle  = 1'b0;
    if (phase_change) begin
      if (dec_phase == PH_ILLEGAL) begin
        ev_onehot = 1'b1;
      end else if ((phase_q != PH_ILLEGAL) && !legal_step(phase_q, dec_phase)) begin
        ev_seq = 1'b1;
      end
      ev_cycle = (phase_q == PH_RED) && (dec_phase == PH_GREEN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt   <= '0;
      phase_len <= '0;
      len_valid <= 1'b0;
    end else begin
      len_valid <= phase_change;
      if (phase_change) begin
        phase_len <= run_cnt;
        run_cnt   <= CNT_ONE;
      end else if (run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + CNT_ONE;
      end
    end
  end

  // A same-edge event beats clr so that nothing is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      cycle_cnt  <= '0;
    end else if (clr) begin
      err_onehot <= ev_onehot;
      err_seq    <= ev_seq;
      cycle_cnt  <= ev_cycle ? CYC_ONE : '0;
    end else begin
      err_onehot <= err_onehot | ev_onehot;
      err_seq    <= err_seq | ev_seq;
      if (ev_cycle) begin
        cycle_cnt <= cycle_cnt + CYC_ONE;
      end
    end
  end

  assign phase = phase_q;

endmodule
